axi_rd_arbiter: RTL and testbench

Read-channel arbiter between the CNN IP's two fetch engines (IFM fetch, requester 0; weight fetch, requester 1) and the single AXI4 read address/data port of the AXI master. It accepts burst requests from both, grants them round-robin onto AR, and records grant order in a small order FIFO. R beats are routed back in order to the owning requester, with RLAST/length checking.

---
 rtl/cnn_axi_pkg.sv | 22 ++
 rtl/burst_order_fifo.sv | 66 ++++++
 rtl/axi_rd_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_axi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cnn_axi_pkg
// Description : Shared types and constants for the CNN IP AXI read path.
//               Provides the AR-channel FSM state type, requester indices
//               and the AXI burst/response encodings used by the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_axi_pkg;

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_ADDR = 1'b1
  } ar_state_t;

  localparam int         REQ_IFM        = 0;
  localparam int         REQ_WGT        = 1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage : cnn_axi_pkg
`default_nettype wire

// File: rtl/burst_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : burst_order_fifo
// Description : Synchronous first-word-fall-through FIFO holding the
//               {id, len} of every AR burst issued and not yet completed.
//               The head entry is visible on head_o whenever empty_o is 0.
// Ports       : clk_i, rst_i (async, active high)
//               push_i/din_i  - write an entry (ignored when full)
//               pop_i         - drop the head entry (ignored when empty)
//               head_o        - oldest entry
//               count_o       - number of stored entries (0..DEPTH)
//               full_o/empty_o
// Revision    : 1.0 - initial release
// ============================================================================
module burst_order_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule : burst_order_fifo
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Round-robin arbiter between the IFM fetch (requester 0) and
//               weight fetch (requester 1) engines onto one AXI4 read port.
//               Grant order is recorded in burst_order_fifo; R beats are
//               routed combinationally to the owner of the oldest burst, with
//               RRESP, RLAST/length and unexpected-RVALID error detection.
// Ports       : ACLK/ARESET        - clock, async active-high reset
//               REQ_*              - burst requests from the two engines
//               DATA_*             - R beats back to the engines
//               M_AXI_AR*/R*       - AXI4 read address/data channels
//               OUTSTANDING        - bursts issued and not yet completed
//               ERR                - sticky [0] bad RRESP, [1] RLAST/length
//                                    mismatch, [2] RVALID with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
  import cnn_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int AXI_WIDTH  = 256,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUT    = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [1:0]                  REQ_VALID,
  input  logic [ADDR_WIDTH-1:0]       REQ_ADDR0,
  input  logic [ADDR_WIDTH-1:0]       REQ_ADDR1,
  input  logic [LEN_WIDTH-1:0]        REQ_LEN0,
  input  logic [LEN_WIDTH-1:0]        REQ_LEN1,
  output logic [1:0]                  REQ_READY,
  output logic [1:0]                  DATA_VALID,
  output logic                        DATA_LAST,
  output logic [AXI_WIDTH-1:0]        DATA_OUT,
  input  logic [1:0]                  DATA_READY,
  output logic [ID_WIDTH-1:0]         M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]       M_AXI_ARADDR,
  output logic [LEN_WIDTH-1:0]        M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [AXI_WIDTH-1:0]        M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic [$clog2(MAX_OUT):0]    OUTSTANDING,
  output logic [2:0]                  ERR
);

  localparam int FW = ID_WIDTH + LEN_WIDTH;

  ar_state_t             state_q, state_d;
  logic                  last_q, last_d;      // 1: requester 1 was granted last
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [2:0]            err_q, err_d;

  logic                  win;
  logic                  grant;
  logic                  push;
  logic                  pop;
  logic [FW-1:0]         head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ID_WIDTH-1:0]   head_id;
  logic [LEN_WIDTH-1:0]  head_len;
  logic                  head_wgt;
  logic                  r_hs;

  // ---------------------------------------------------------------- AR side
  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    win = REQ_VALID[REQ_WGT];
    if (REQ_VALID == 2'b11) win = ~last_q;
  end

  assign grant = (state_q == AR_IDLE) && (|REQ_VALID) && !fifo_full;
  assign push  = (state_q == AR_ADDR) && M_AXI_ARREADY;

  assign REQ_READY[REQ_IFM] = grant && !win;
  assign REQ_READY[REQ_WGT] = grant && win;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arid_d   = arid_q;
    case (state_q)
      AR_IDLE: begin
        if (grant) begin
          araddr_d = win ? REQ_ADDR1 : REQ_ADDR0;
          arlen_d  = win ? REQ_LEN1  : REQ_LEN0;
          arid_d   = ID_WIDTH'(win);
          state_d  = AR_ADDR;
        end
      end
      AR_ADDR: begin
        if (M_AXI_ARREADY) begin
          last_d  = (arid_q == ID_WIDTH'(REQ_WGT));
          state_d = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase
  end

  assign M_AXI_ARID    = arid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = 3'($clog2(AXI_WIDTH/8));
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARVALID = (state_q == AR_ADDR);

  // ---------------------------------------------------------- order FIFO
  burst_order_fifo #(
    .WIDTH (FW),
    .DEPTH (MAX_OUT)
  ) u_order_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (push),
    .din_i   ({arid_q, arlen_q}),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (OUTSTANDING),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ----------------------------------------------------------------- R side
  assign head_id  = head[FW-1 -: ID_WIDTH];
  assign head_len = head[LEN_WIDTH-1:0];
  assign head_wgt = (head_id == ID_WIDTH'(REQ_WGT));

  assign DATA_VALID[REQ_IFM] = M_AXI_RVALID && !fifo_empty && !head_wgt;
  assign DATA_VALID[REQ_WGT] = M_AXI_RVALID && !fifo_empty && head_wgt;
  assign DATA_LAST           = M_AXI_RLAST;
  assign DATA_OUT            = M_AXI_RDATA;
  assign M_AXI_RREADY        = !fifo_empty &&
                               (head_wgt ? DATA_READY[REQ_WGT] : DATA_READY[REQ_IFM]);

  assign r_hs = M_AXI_RVALID && M_AXI_RREADY;
  assign pop  = r_hs && M_AXI_RLAST;

  // A burst is well-formed when RLAST arrives exactly on beat index len;
  // an early RLAST or a missing RLAST on that beat both flag ERR[1].
  always_comb begin
    beat_d = beat_q;
    err_d  = err_q;
    if (r_hs) begin
      beat_d = M_AXI_RLAST ? '0 : beat_q + LEN_WIDTH'(1);
      if (M_AXI_RRESP != AXI_RESP_OKAY) err_d[0] = 1'b1;
      if (M_AXI_RLAST != (beat_q == head_len)) err_d[1] = 1'b1;
    end
    if (M_AXI_RVALID && fifo_empty) err_d[2] = 1'b1;
  end

  assign ERR = err_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= AR_IDLE;
      last_q   <= 1'b1;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
      beat_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arid_q   <= arid_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

endmodule : axi_rd_arbiter
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Directed self-checking bench for axi_rd_arbiter. Expected
//               burst owners/lengths are queued when requests are driven and
//               consumed when the bench plays the R channel back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [1:0]   REQ_VALID = '0;
  logic [31:0]  REQ_ADDR0 = '0, REQ_ADDR1 = '0;
  logic [7:0]   REQ_LEN0 = '0, REQ_LEN1 = '0;
  logic [1:0]   REQ_READY;
  logic [1:0]   DATA_VALID;
  logic         DATA_LAST;
  logic [255:0] DATA_OUT;
  logic [1:0]   DATA_READY = '0;
  logic [3:0]   M_AXI_ARID;
  logic [31:0]  M_AXI_ARADDR;
  logic [7:0]   M_AXI_ARLEN;
  logic [2:0]   M_AXI_ARSIZE;
  logic [1:0]   M_AXI_ARBURST;
  logic         M_AXI_ARVALID;
  logic         M_AXI_ARREADY = 1'b0;
  logic [255:0] M_AXI_RDATA = '0;
  logic [1:0]   M_AXI_RRESP = '0;
  logic         M_AXI_RLAST = 1'b0;
  logic         M_AXI_RVALID = 1'b0;
  logic         M_AXI_RREADY;
  logic [2:0]   OUTSTANDING;
  logic [2:0]   ERR;

  axi_rd_arbiter dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .REQ_VALID     (REQ_VALID),
    .REQ_ADDR0     (REQ_ADDR0),
    .REQ_ADDR1     (REQ_ADDR1),
    .REQ_LEN0      (REQ_LEN0),
    .REQ_LEN1      (REQ_LEN1),
    .REQ_READY     (REQ_READY),
    .DATA_VALID    (DATA_VALID),
    .DATA_LAST     (DATA_LAST),
    .DATA_OUT      (DATA_OUT),
    .DATA_READY    (DATA_READY),
    .M_AXI_ARID    (M_AXI_ARID),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_ARSIZE  (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY),
    .OUTSTANDING   (OUTSTANDING),
    .ERR           (ERR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { int r; int l; } burst_t;
  burst_t bq[$];          // scoreboard: expected burst owner/length in grant order

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    REQ_VALID = '0; DATA_READY = '0; M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = '0;
    step(); step();
    ARESET = 1'b0;
    bq.delete();
    #1;
  endtask

  // Single request from requester r with ARREADY held high.
  task automatic issue(input int r, input logic [31:0] a, input logic [7:0] l);
    int k;
    k = 0;
    if (r == 0) begin REQ_ADDR0 = a; REQ_LEN0 = l; end
    else        begin REQ_ADDR1 = a; REQ_LEN1 = l; end
    REQ_VALID = 2'(1 << r);
    #1;
    while (REQ_READY == 2'b00 && k < 20) begin step(); k++; end
    chk("req_ready", REQ_READY, 256'(1 << r));
    chk("arvalid_in_grant_cycle", M_AXI_ARVALID, 0);
    bq.push_back('{r, int'(l)});
    step();
    REQ_VALID = '0;
    #1;
    chk("arvalid", M_AXI_ARVALID, 1);
    chk("arid", M_AXI_ARID, r);
    chk("araddr", M_AXI_ARADDR, a);
    chk("arlen", M_AXI_ARLEN, l);
    step();
    chk("outstanding_after_ar", OUTSTANDING, bq.size());
  endtask

  // Play one burst back; lastpos < 0 puts RLAST on the correct final beat.
  task automatic burst(input int lastpos, input logic [1:0] resp);
    burst_t b;
    int n;
    logic [255:0] d;
    if (bq.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    b = bq.pop_front();
    n = (lastpos < 0) ? b.l : lastpos;
    DATA_READY = 2'b11;
    for (int i = 0; i <= n; i++) begin
      d = {8{$urandom()}};
      M_AXI_RDATA  = d;
      M_AXI_RVALID = 1'b1;
      M_AXI_RLAST  = (i == n);
      M_AXI_RRESP  = resp;
      #1;
      chk("data_valid_owner", DATA_VALID, 256'(1 << b.r));
      chk("data_out", DATA_OUT, d);
      chk("data_last", DATA_LAST, (i == n));
      chk("rready", M_AXI_RREADY, 1);
      step();
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = '0;
    chk("outstanding_after_burst", OUTSTANDING, bq.size());
  endtask

  initial begin
    int ord [4];
    int k;
    ord = '{0, 1, 0, 1};

    // ---- reset state
    step();
    chk("rst_arvalid", M_AXI_ARVALID, 0);
    chk("rst_rready", M_AXI_RREADY, 0);
    chk("rst_req_ready", REQ_READY, 0);
    chk("rst_data_valid", DATA_VALID, 0);
    chk("rst_araddr", M_AXI_ARADDR, 0);
    chk("rst_arlen", M_AXI_ARLEN, 0);
    chk("rst_arid", M_AXI_ARID, 0);
    chk("rst_outstanding", OUTSTANDING, 0);
    chk("rst_err", ERR, 0);
    do_reset();

    // ---- single 256-beat burst for requester 0
    M_AXI_ARREADY = 1'b1;
    issue(0, 32'h1000, 8'd255);
    chk("arsize", M_AXI_ARSIZE, 5);
    chk("arburst", M_AXI_ARBURST, 2'b01);
    chk("outstanding_1", OUTSTANDING, 1);
    burst(-1, 2'b00);
    chk("outstanding_0", OUTSTANDING, 0);
    chk("err_clean_1", ERR, 0);

    // ---- both requesters, round-robin, order FIFO fills up
    do_reset();
    M_AXI_ARREADY = 1'b1;
    REQ_ADDR0 = 32'h2000; REQ_ADDR1 = 32'h3000;
    REQ_LEN0 = 8'd3;      REQ_LEN1 = 8'd3;
    REQ_VALID = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (REQ_READY == 2'b00 && k < 10) begin step(); k++; end
      chk("rr_grant", REQ_READY, 256'(1 << ord[g]));
      bq.push_back('{ord[g], 3});
      step();
      chk("rr_arid", M_AXI_ARID, ord[g]);
      chk("rr_araddr", M_AXI_ARADDR, (ord[g] == 1) ? 32'h3000 : 32'h2000);
    end
    step();
    chk("full_outstanding", OUTSTANDING, 4);
    for (int i = 0; i < 6; i++) begin
      chk("full_blocks_grant", REQ_READY, 0);
      chk("full_no_arvalid", M_AXI_ARVALID, 0);
      step();
    end
    burst(-1, 2'b00);
    chk("fifth_grant_after_pop", REQ_READY, 2'b01);
    bq.push_back('{0, 3});
    step();
    REQ_VALID = '0;
    chk("fifth_arid", M_AXI_ARID, 0);
    step();
    chk("refilled", OUTSTANDING, 4);
    while (bq.size() > 0) burst(-1, 2'b00);
    chk("rr_drained", OUTSTANDING, 0);
    chk("err_clean_2", ERR, 0);

    // ---- ids 1 then 0, DATA_READY[1] low stalls the first burst
    issue(1, 32'h4000, 8'd3);
    issue(0, 32'h5000, 8'd3);
    DATA_READY = 2'b01;
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA = 256'h5a5a;
    #1;
    chk("stall_rready", M_AXI_RREADY, 0);
    chk("stall_data_valid", DATA_VALID, 2'b10);
    step();
    chk("stall_rready_held", M_AXI_RREADY, 0);
    M_AXI_RVALID = 1'b0;
    burst(-1, 2'b00);
    burst(-1, 2'b00);
    chk("err_clean_3", ERR, 0);

    // ---- ARREADY low for 10 cycles
    M_AXI_ARREADY = 1'b0;
    REQ_ADDR0 = 32'h6000; REQ_LEN0 = 8'd15;
    REQ_VALID = 2'b01;
    #1;
    chk("stall_ar_grant", REQ_READY, 2'b01);
    bq.push_back('{0, 15});
    step();
    REQ_VALID = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("ar_hold_valid", M_AXI_ARVALID, 1);
      chk("ar_hold_addr", M_AXI_ARADDR, 32'h6000);
      chk("ar_hold_len", M_AXI_ARLEN, 15);
      chk("ar_hold_no_grant", REQ_READY, 0);
      step();
    end
    REQ_VALID = '0;
    M_AXI_ARREADY = 1'b1;
    step();
    chk("ar_hold_pushed", OUTSTANDING, 1);
    burst(-1, 2'b00);
    chk("err_clean_4", ERR, 0);

    // ---- error detection
    issue(0, 32'h7000, 8'd7);
    burst(2, 2'b00);
    chk("err_early_last", ERR, 3'b010);
    chk("early_last_popped", OUTSTANDING, 0);
    M_AXI_RVALID = 1'b1;
    #1;
    chk("empty_rready", M_AXI_RREADY, 0);
    chk("empty_data_valid", DATA_VALID, 0);
    step();
    M_AXI_RVALID = 1'b0;
    chk("err_unexpected_rvalid", ERR, 3'b110);
    issue(1, 32'h8000, 8'd0);
    burst(-1, 2'b10);
    chk("err_rresp", ERR, 3'b111);

    // ---- reset in the middle of traffic
    issue(0, 32'h9000, 8'd7);
    issue(1, 32'hA000, 8'd7);
    chk("pre_reset_outstanding", OUTSTANDING, 2);
    M_AXI_ARREADY = 1'b0;
    REQ_ADDR0 = 32'hB000;
    REQ_VALID = 2'b01;
    step();
    REQ_VALID = '0;
    chk("pre_reset_arvalid", M_AXI_ARVALID, 1);
    DATA_READY = 2'b11;
    M_AXI_RVALID = 1'b1;
    step();
    #2;
    ARESET = 1'b1;
    #1;
    chk("mid_rst_outstanding", OUTSTANDING, 0);
    chk("mid_rst_arvalid", M_AXI_ARVALID, 0);
    chk("mid_rst_err", ERR, 0);
    chk("mid_rst_rready", M_AXI_RREADY, 0);
    chk("mid_rst_data_valid", DATA_VALID, 0);
    M_AXI_RVALID = 1'b0;
    step();
    ARESET = 1'b0;
    bq.delete();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_axi_rd_arbiter
`default_nettype wire
